instrmem_fetch: RTL and testbench

Parametrised, writable instruction memory with a registered, handshaked fetch port; the successor to the combinational fixed-program instruction ROM. It sits between the fetch stage and a program-load port (debug or boot loader). After reset it hardware-fills every word with NOP, then serves fetches with one-cycle latency, backpressure and error reporting.

---
 rtl/instrmem_pkg.sv | 23 ++
 rtl/instrmem_bank.sv | 32 +++
 rtl/instrmem_fetch.sv | 154 +++++++++++++++
 tb/tb_instrmem_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instrmem_pkg.sv
// Shared constants, error codes, FSM state constants and the parity helper
// for the writable instruction memory.
package instrmem_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_PARITY   = 2'd3
  } err_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_FILL = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [31:0] i_word);
    return ^i_word;
  endfunction

endpackage

// File: rtl/instrmem_bank.sv
// Instruction storage array: one synchronous read-first read port and one
// write port, both on the rising edge of clk.
module instrmem_bank #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Read and write in the same edge: the read samples the old contents.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instrmem_fetch.sv
// Writable instruction memory with NOP fill after reset and a registered,
// handshaked fetch port. Optional per-word parity via INSTRMEM_PARITY_EN.
module instrmem_fetch
  import instrmem_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [1:0]               rsp_err,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
`ifdef INSTRMEM_PARITY_EN
  localparam int WIDTH = 33;
`else
  localparam int WIDTH = 32;
`endif

  state_t           r_state;
  logic [AW-1:0]    r_fill_cnt;
  logic             r_valid;
  logic [1:0]       r_err;
  logic             r_sel_mem;
  logic             r_busy;

  logic             w_accept;
  logic             w_misalign;
  logic             w_range;
  logic [AW-1:0]    w_index;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_addr;
  logic [31:0]      w_wr_data;
  logic [WIDTH-1:0] w_bank_wdata;
  logic [WIDTH-1:0] w_bank_rdata;
  logic             w_par_bad;

  assign req_ready  = !rst && (r_state == ST_RUN) && (!r_valid || rsp_ready);
  assign w_accept   = req_valid && req_ready;
  assign w_misalign = (req_addr[1:0] != 2'b00);
  assign w_range    = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign w_index    = req_addr[AW+1:2];

  // Write port owner: fill engine during FILL, program port during RUN.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = NOP_WORD;
    if (rst) begin
      w_wr_en = 1'b0;
    end else if (r_state == ST_FILL) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_fill_cnt;
      w_wr_data = NOP_WORD;
    end else begin
      w_wr_en   = prog_we;
      w_wr_addr = prog_addr;
      w_wr_data = prog_data;
    end
  end

`ifdef INSTRMEM_PARITY_EN
  assign w_bank_wdata = {even_parity(w_wr_data), w_wr_data};
  assign w_par_bad    = r_sel_mem && (even_parity(w_bank_rdata[31:0]) != w_bank_rdata[32]);
`else
  assign w_bank_wdata = w_wr_data;
  assign w_par_bad    = 1'b0;
`endif

  instrmem_bank #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_bank (
    .clk     (clk),
    .i_re    (w_accept),
    .i_raddr (w_index),
    .o_rdata (w_bank_rdata),
    .i_we    (w_wr_en),
    .i_waddr (w_wr_addr),
    .i_wdata (w_bank_wdata)
  );

  // FSM, fill counter and the one-entry response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FILL;
      r_fill_cnt <= '0;
      r_valid    <= 1'b0;
      r_err      <= ERR_OK;
      r_sel_mem  <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_FILL: begin
          r_fill_cnt <= r_fill_cnt + AW'(1);
          if (r_fill_cnt == AW'(DEPTH - 1)) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_valid   <= 1'b1;
            r_sel_mem <= !w_misalign && !w_range;
            if (w_misalign) begin
              r_err <= ERR_MISALIGN;
            end else if (w_range) begin
              r_err <= ERR_RANGE;
            end else begin
              r_err <= ERR_OK;
            end
          end else if (rsp_ready) begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

  // Error responses carry NOP; parity errors return the stored word as-is.
  always_comb begin
    rsp_data = NOP_WORD;
    rsp_err  = r_err;
    if (r_sel_mem) begin
      rsp_data = w_bank_rdata[31:0];
    end else begin
      rsp_data = NOP_WORD;
    end
    if (w_par_bad) begin
      rsp_err = ERR_PARITY;
    end else begin
      rsp_err = r_err;
    end
  end

  assign rsp_valid = r_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_instrmem_fetch.sv
// Self-checking bench for instrmem_fetch: directed scenarios plus a
// randomized run against a word-array / response-queue reference model.
module tb_instrmem_fetch;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic        busy;

  instrmem_fetch #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  err;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] m_mem [DEPTH];
  int          m_edges;
  int          n_checks;
  int          n_errors;
  logic        obs_ready;
  logic        m_ready;

  function automatic resp_t ref_fetch(input logic [31:0] a);
    resp_t r;
    if (a % 4 != 0) begin
      r.err = 2'd1; r.data = NOP;
    end else if (a / 4 >= DEPTH) begin
      r.err = 2'd2; r.data = NOP;
    end else begin
      r.err = 2'd0; r.data = m_mem[int'(a / 4)];
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    m_edges = 0;
  endtask

  // One clock: drive inputs, sample ready, advance the model across the edge.
  task automatic step(input logic rv, input logic [31:0] a, input logic rr,
                      input logic we, input logic [5:0] wa, input logic [31:0] wd);
    req_valid = rv; req_addr = a; rsp_ready = rr;
    prog_we = we; prog_addr = wa; prog_data = wd;
    #1;
    obs_ready = req_ready;
    m_ready   = (m_edges >= DEPTH) && (exp_q.size() == 0 || rr);
    @(posedge clk);
    if (m_edges >= DEPTH) begin
      if (exp_q.size() > 0 && rr) void'(exp_q.pop_front());
      if (rv && m_ready) exp_q.push_back(ref_fetch(a));
      if (we) m_mem[wa] = wd;
    end
    m_edges++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || rsp_data !== NOP || rsp_err !== 2'd0 || req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: valid=%b busy=%b data=%h err=%0d ready=%b, want 0 1 %h 0 0",
               rsp_valid, busy, rsp_data, rsp_err, req_ready, NOP);
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_errors++; $display("FAIL fill_busy cycle %0d: busy=%b want 1", i + 1, busy);
      end
      step(1'b1, 32'h0, 1'b1, 1'b1, 6'(i), 32'hFFFF_FFFF);
      n_checks++;
      if (obs_ready !== 1'b0) begin
        n_errors++; $display("FAIL fill_ready cycle %0d: ready=%b want 0", i + 1, obs_ready);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL fill_done: busy=%b want 0", busy);
    end
    step(1'b1, 32'h0, 1'b1, 1'b0, 6'd0, 32'h0);
    n_checks++;
    if (obs_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0013 || rsp_err !== 2'd0) begin
      n_errors++;
      $display("FAIL first_fetch: ready=%b valid=%b data=%h err=%0d, want 1 1 00000013 0",
               obs_ready, rsp_valid, rsp_data, rsp_err);
    end
  endtask

  task automatic test_program_fetch();
    step(1'b0, 32'h0, 1'b1, 1'b1, 6'd5, 32'h00A0_0513);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL drain: valid=%b want 0", rsp_valid);
    end
    step(1'b1, 32'h14, 1'b1, 1'b0, 6'd0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h00A0_0513 || rsp_err !== 2'd0) begin
      n_errors++;
      $display("FAIL prog_fetch: valid=%b data=%h err=%0d, want 1 00a00513 0", rsp_valid, rsp_data, rsp_err);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic [1:0]  errs  [3];
    addrs = '{32'h16, 32'h100, 32'h102};
    errs  = '{2'd1, 2'd2, 2'd1};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, addrs[i], 1'b1, 1'b0, 6'd0, 32'h0);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== NOP || rsp_err !== errs[i]) begin
        n_errors++;
        $display("FAIL err_fetch %h: valid=%b data=%h err=%0d, want 1 %h %0d",
                 addrs[i], rsp_valid, rsp_data, rsp_err, NOP, errs[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    step(1'b1, 32'hC, 1'b1, 1'b1, 6'd3, 32'hDEAD_BEEF);
    n_checks++;
    if (rsp_data !== NOP || rsp_err !== 2'd0) begin
      n_errors++; $display("FAIL read_first: data=%h err=%0d, want %h 0", rsp_data, rsp_err, NOP);
    end
    step(1'b1, 32'hC, 1'b1, 1'b0, 6'd0, 32'h0);
    n_checks++;
    if (rsp_data !== 32'hDEAD_BEEF || rsp_err !== 2'd0) begin
      n_errors++; $display("FAIL after_write: data=%h err=%0d, want deadbeef 0", rsp_data, rsp_err);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    int got;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 6'(8 + i), 32'h1000_0008 + 32'(i));
    step(1'b1, 32'h20, 1'b1, 1'b0, 6'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h24, 1'b0, 1'b0, 6'd0, 32'h0);
      n_checks++;
      if (obs_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'h1000_0008) begin
        n_errors++;
        $display("FAIL stall %0d: ready=%b valid=%b data=%h, want 0 1 10000008", i, obs_ready, rsp_valid, rsp_data);
      end
    end
    a = 32'h24;
    got = 0;
    for (int c = 0; c < 10 && got < 4; c++) begin
      if (rsp_valid === 1'b1) begin
        n_checks++;
        if (rsp_data !== 32'h1000_0008 + 32'(got)) begin
          n_errors++; $display("FAIL stream %0d: data=%h want %h", got, rsp_data, 32'h1000_0008 + 32'(got));
        end
        got++;
      end
      step(a <= 32'h2C, a, 1'b1, 1'b0, 6'd0, 32'h0);
      if (obs_ready && a <= 32'h2C) a = a + 32'd4;
    end
    n_checks++;
    if (got != 4) begin
      n_errors++; $display("FAIL stream_count: got=%0d want 4", got);
    end
  endtask

  task automatic test_random();
    int r;
    logic [31:0] a;
    for (int it = 0; it < 400; it++) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        if (rsp_valid !== 1'b0) begin
          n_errors++; $display("FAIL rand_idle %0d: valid=%b want 0", it, rsp_valid);
        end
      end else if (rsp_valid !== 1'b1 || rsp_data !== exp_q[0].data || rsp_err !== exp_q[0].err) begin
        n_errors++;
        $display("FAIL rand_rsp %0d: valid=%b data=%h err=%0d, want 1 %h %0d",
                 it, rsp_valid, rsp_data, rsp_err, exp_q[0].data, exp_q[0].err);
      end
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      else if (r == 7) a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else             a = ($urandom() | 32'h0000_0100) & 32'hFFFF_FFFC;
      step(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 3) == 0), 6'($urandom_range(0, 63)), $urandom());
      n_checks++;
      if (obs_ready !== m_ready) begin
        n_errors++; $display("FAIL rand_ready %0d: ready=%b want %b", it, obs_ready, m_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 32'h0, 1'b1, 1'b1, 6'd5, 32'h00A0_0513);
    step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0, 32'h0);
    step(1'b1, 32'h14, 1'b0, 1'b0, 6'd0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h00A0_0513) begin
      n_errors++; $display("FAIL pre_reset: valid=%b data=%h, want 1 00a00513", rsp_valid, rsp_data);
    end
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL mid_reset: valid=%b busy=%b, want 0 1", rsp_valid, busy);
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0, 32'h0);
    step(1'b1, 32'h14, 1'b1, 1'b0, 6'd0, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== NOP || rsp_err !== 2'd0) begin
      n_errors++;
      $display("FAIL refill: valid=%b data=%h err=%0d, want 1 %h 0", rsp_valid, rsp_data, rsp_err, NOP);
    end
`ifdef INSTRMEM_PARITY_EN
    dut.u_bank.r_mem[7][0] = ~dut.u_bank.r_mem[7][0];
    step(1'b1, 32'h1C, 1'b1, 1'b0, 6'd0, 32'h0);
    n_checks++;
    if (rsp_err !== 2'd3 || rsp_data !== 32'h0000_0012) begin
      n_errors++; $display("FAIL parity: data=%h err=%0d, want 00000012 3", rsp_data, rsp_err);
    end
`endif
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
    prog_we = 1'b0; prog_addr = 6'd0; prog_data = 32'h0;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    test_reset();
    test_program_fetch();
    test_errors();
    test_same_cycle();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
